mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//  Memory stage of the 5-stage ARM pipeline. Sits between EXE_Stage_Reg and MEM_Stage_Reg.
//  Turns LDR/STR requests into two 16-bit accesses on an external single-port SRAM with wait states.
//  Asserts freeze to stall IF/ID/EXE and their registers until the 32-bit access completes.
//  Non-memory instructions pass through with zero added latency.
// PARAMETERS
//  WAIT_CYCLES  2     cycles each 16-bit SRAM access is held (>=1)
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
//  SRAM_AW      18    SRAM halfword address width
// PORTS
//  clk          in   1   pipeline clock
//  rst          in   1   synchronous, active-low reset
//  wb_en_in     in   1   from EXE_Stage_Reg
//  mem_r_en_in  in   1   load request
//  mem_w_en_in  in   1   store request
//  alu_res_in   in   32  byte address (load/store) or ALU result
//  val_rm_in    in   32  store data
//  dest_in      in   4   destination register
//  wb_en_out    out  1   to MEM_Stage_Reg, = wb_en_in
//  mem_r_en_out out  1   = mem_r_en_in
//  alu_res_out  out  32  = alu_res_in
//  dest_out     out  4   = dest_in
//  mem_data_out out  32  assembled load data (registered)
//  freeze       out  1   stall for upstream stages and pipeline registers
//  sram_addr    out  SRAM_AW  halfword address
//  sram_wdata   out  16  write data
//  sram_rdata   in   16  read data, valid while the access is held
//  sram_we_n    out  1   active-low write strobe
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state IDLE, wait counter 0, mem_data_out 0, sram_we_n 1, sram_addr 0, sram_wdata 0.
//  Address: word = (alu_res_in - BASE_ADDR) >> 2. Low half = {word[SRAM_AW-2:0],1'b0}; high half = low half + 1. Bits [1:0] are ignored.
//  Request = mem_r_en_in | mem_w_en_in. If both are set, the write takes precedence.
//  FSM: IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: freeze = request (combinational). On a request, go to LO and clear the counter.
//   LO:   drive low-half address; for writes, sram_wdata = val_rm[15:0] and sram_we_n = 0.
//         Stay WAIT_CYCLES cycles. On the last cycle, a read latches sram_rdata into data[15:0].
//   HI:   same as LO for the high half with val_rm[31:16] / data[31:16].
//   DONE: freeze = 0. mem_data_out holds the assembled word. The pipeline advances this edge; return to IDLE.
//  freeze = 1 for 1 + 2*WAIT_CYCLES cycles per access. The result is visible in the DONE cycle.
//  Inputs are stable while frozen. DONE deasserts freeze for exactly one cycle, so the same instruction is never reissued.
//  sram_we_n = 1 in IDLE and DONE. Read data updates only on the last cycle of LO/HI. mem_data_out holds between loads.
//  Back-to-back memory instructions: IDLE sees the next request the cycle after DONE.
//  Reset mid-access: abort immediately to IDLE. freeze drops to 0 and sram_we_n to 1; a partially written word is left in SRAM.
//  Non-memory instruction: freeze = 0; pass-through outputs only.
// CONFIGURATION
//  MEM_STAGE_READ_BUF_EN defined: one-entry buffer of {valid, word address, data}.
//   A load whose word address equals the buffered one with valid = 1 goes IDLE -> DONE directly: freeze = 0 in IDLE, 1-cycle total.
//   Every completed load refills the buffer. Any store invalidates it. Reset clears valid.
//  Not defined: every load performs both SRAM accesses; no buffer storage is generated.
// STRUCTURE
//  Package mem_stage_pkg: state enum (S_IDLE, S_LO, S_HI, S_DONE), BASE_ADDR default, halfword width constant.
//  Sub-module sram_wait_counter: load/clear, terminal-count flag at WAIT_CYCLES-1. Instantiated once.
// TESTING
//  1. Reset: rst=0 two cycles -> freeze=0, sram_we_n=1, mem_data_out=0, state IDLE.
//  2. STR val_rm=0xDEADBEEF at addr 1032, WAIT_CYCLES=2:
//     -> freeze high 5 cycles; sram_addr 4 (2 cycles) with wdata 0xBEEF then 5 (2 cycles) with 0xDEAD; we_n low on those 4 cycles.
//  3. LDR addr 1032 with SRAM model holding 0xBEEF/0xDEAD
//     -> mem_data_out=0xDEADBEEF in the DONE cycle; freeze low that cycle.
//  4. ADD (no mem enables), alu_res=7, dest=3 -> freeze stays 0; alu_res_out=7, dest_out=3 in the same cycle; SRAM idle.
//  5. rst=0 during the HI phase of a store -> next cycle IDLE, freeze=0, we_n=1; a following LDR completes normally.
//  6. With MEM_STAGE_READ_BUF_EN: LDR 1040, then LDR 1040 -> second has freeze=0 and the same data.
//     STR 1040 then LDR 1040 -> full 5-cycle access.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_stage_pkg                                                |
// | Description : Shared types and constants for the memory-stage SRAM control.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned c_base_addr_default = 1024;
    localparam int          c_half_w            = 16;

endpackage
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_wait_counter                                            |
// | Description : Wait-state counter; flags the last cycle of an SRAM access.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int                 c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WAIT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_tc = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_sram_ctrl                                          |
// | Description : Memory stage; splits LDR/STR into two 16-bit SRAM accesses   |
// |               and freezes the upstream pipeline until the word completes.  |
// |               Optional read buffer: MEM_STAGE_READ_BUF_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = c_base_addr_default,
    parameter int          SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_en_in,
    input  logic                mem_r_en_in,
    input  logic                mem_w_en_in,
    input  logic [31:0]         alu_res_in,
    input  logic [31:0]         val_rm_in,
    input  logic [3:0]          dest_in,
    output logic                wb_en_out,
    output logic                mem_r_en_out,
    output logic [31:0]         alu_res_out,
    output logic [3:0]          dest_out,
    output logic [31:0]         mem_data_out,
    output logic                freeze,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [c_half_w-1:0] sram_wdata,
    input  logic [c_half_w-1:0] sram_rdata,
    output logic                sram_we_n
);

    state_t              r_state;
    logic                r_is_write;
    logic [c_half_w-1:0] r_lo_data;
    logic                w_tc;
    logic                w_req;
    logic                w_is_write;
    logic                w_hit;
    logic                w_freeze;
    logic                w_busy;
    logic [31:0]         w_off;
    logic [SRAM_AW-2:0]  w_word;
    logic                w_unused_bits;

    assign w_off         = alu_res_in - 32'(BASE_ADDR);
    assign w_word        = w_off[SRAM_AW:2];
    assign w_unused_bits = &{1'b0, w_off[31:SRAM_AW+1], w_off[1:0]};
    assign w_req         = mem_r_en_in | mem_w_en_in;
    assign w_is_write    = mem_w_en_in;
    assign w_busy        = (r_state == S_LO) || (r_state == S_HI);

`ifdef MEM_STAGE_READ_BUF_EN
    logic               r_buf_valid;
    logic [SRAM_AW-2:0] r_buf_word;
    logic [31:0]        r_buf_data;

    assign w_hit = r_buf_valid && mem_r_en_in && !w_is_write && (r_buf_word == w_word);
`else
    assign w_hit = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_busy || w_tc),
        .i_en    (w_busy),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_freeze = 1'b0;
        case (r_state)
            S_IDLE:  w_freeze = w_req && !w_hit;
            S_LO:    w_freeze = 1'b1;
            S_HI:    w_freeze = 1'b1;
            default: w_freeze = 1'b0;
        endcase
    end

    // Gated by reset so an aborted access releases the pipeline at once.
    assign freeze = rst & w_freeze;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_lo_data    <= '0;
            mem_data_out <= '0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_we_n    <= 1'b1;
`ifdef MEM_STAGE_READ_BUF_EN
            r_buf_valid  <= 1'b0;
            r_buf_word   <= '0;
            r_buf_data   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
`ifdef MEM_STAGE_READ_BUF_EN
                        mem_data_out <= r_buf_data;
`endif
                        r_state      <= S_DONE;
                    end else if (w_req) begin
                        r_state    <= S_LO;
                        r_is_write <= w_is_write;
                        sram_addr  <= {w_word, 1'b0};
                        sram_wdata <= val_rm_in[15:0];
                        sram_we_n  <= !w_is_write;
`ifdef MEM_STAGE_READ_BUF_EN
                        if (w_is_write) begin
                            r_buf_valid <= 1'b0;
                        end
`endif
                    end
                end
                S_LO: begin
                    if (w_tc) begin
                        if (!r_is_write) begin
                            r_lo_data <= sram_rdata;
                        end
                        r_state    <= S_HI;
                        sram_addr  <= {w_word, 1'b1};
                        sram_wdata <= val_rm_in[31:16];
                    end
                end
                S_HI: begin
                    if (w_tc) begin
                        if (!r_is_write) begin
                            mem_data_out <= {sram_rdata, r_lo_data};
`ifdef MEM_STAGE_READ_BUF_EN
                            r_buf_valid  <= 1'b1;
                            r_buf_word   <= w_word;
                            r_buf_data   <= {sram_rdata, r_lo_data};
`endif
                        end
                        r_state   <= S_DONE;
                        sram_we_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_en_out    = wb_en_in;
    assign mem_r_en_out = mem_r_en_in;
    assign alu_res_out  = alu_res_in;
    assign dest_out     = dest_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage_sram_ctrl                                       |
// | Description : Directed and randomized bench for mem_stage_sram_ctrl.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage_sram_ctrl;

    localparam int c_wait = 2;
    localparam int c_aw   = 18;
    localparam int c_base = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0]       alu_res_in, val_rm_in;
    logic [3:0]        dest_in;
    logic              wb_en_out, mem_r_en_out;
    logic [31:0]       alu_res_out, mem_data_out;
    logic [3:0]        dest_out;
    logic              freeze;
    logic [c_aw-1:0]   sram_addr;
    logic [15:0]       sram_wdata, sram_rdata;
    logic              sram_we_n;

    logic [15:0] tb_sram [0:255] = '{default: 16'h0};

    int n_checks   = 0;
    int n_failures = 0;

    logic [c_aw-1:0] tr_addr [0:15];
    logic [15:0]     tr_wd   [0:15];
    logic            tr_we   [0:15];
    logic            done_we_n;

    logic [31:0] ref_mem [int];
    logic        rb_valid = 1'b0;
    int          rb_word  = 0;

    always #5 clk = ~clk;

    assign sram_rdata = tb_sram[sram_addr[7:0]];
    always @(posedge clk) if (!sram_we_n) tb_sram[sram_addr[7:0]] <= sram_wdata;

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (c_wait),
        .BASE_ADDR   (c_base),
        .SRAM_AW     (c_aw)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .alu_res_in   (alu_res_in),
        .val_rm_in    (val_rm_in),
        .dest_in      (dest_in),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .dest_out     (dest_out),
        .mem_data_out (mem_data_out),
        .freeze       (freeze),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_we_n    (sram_we_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = 32'h0;
        val_rm_in   = 32'h0;
        dest_in     = 4'h0;
    endtask

    // Issues one memory instruction (called just after a rising edge) and
    // returns the number of frozen cycles and the data seen when it completes.
    task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, output int frz,
                         output logic [31:0] rdata, output logic timeout);
        int  n;
        bit  done;
        mem_w_en_in = wr;
        mem_r_en_in = rd;
        wb_en_in    = rd & ~wr;
        alu_res_in  = addr;
        val_rm_in   = wdata;
        dest_in     = 4'(addr[5:2]);
        frz = 0; rdata = '0; timeout = 1'b1; done = 1'b0; n = 0; done_we_n = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (freeze) begin
                if (frz < 16) begin
                    tr_addr[frz] = sram_addr;
                    tr_wd[frz]   = sram_wdata;
                    tr_we[frz]   = sram_we_n;
                end
                frz++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
            n++;
        end
        if (done) begin
            timeout = 1'b0;
            if (frz == 0) begin
                @(posedge clk); #1;
                idle_inputs();
                @(negedge clk);
            end
            rdata     = mem_data_out;
            done_we_n = sram_we_n;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // Reference: word-addressed memory, one full 32-bit word per access.
    task automatic model_op(input logic wr, input int word, input logic [31:0] wdata,
                            output int exp_frz, output logic [31:0] exp_data);
        bit buf_en;
`ifdef MEM_STAGE_READ_BUF_EN
        buf_en = 1'b1;
`else
        buf_en = 1'b0;
`endif
        exp_data = '0;
        if (wr) begin
            ref_mem[word] = wdata;
            rb_valid      = 1'b0;
            exp_frz       = 1 + 2 * c_wait;
        end else begin
            exp_data = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
            exp_frz  = (buf_en && rb_valid && rb_word == word) ? 0 : 1 + 2 * c_wait;
            rb_valid = buf_en;
            rb_word  = word;
        end
    endtask

    initial begin
        int          frz, exp_frz, word, kind;
        logic [31:0] rdata, exp_data, data, addr;
        logic        tmo;

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_freeze", 32'(freeze), 32'h0);
        chk("reset_we_n", 32'(sram_we_n), 32'h1);
        chk("reset_mem_data", mem_data_out, 32'h0);
        chk("reset_sram_addr", 32'(sram_addr), 32'h0);
        chk("reset_sram_wdata", 32'(sram_wdata), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1032: halfwords 4 and 5.
        model_op(1'b1, 2, 32'hDEADBEEF, exp_frz, exp_data);
        do_op(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, frz, rdata, tmo);
        chk("str_timeout", 32'(tmo), 32'h0);
        chk("str_freeze_cycles", 32'(frz), 32'(exp_frz));
        chk("str_idle_we_n", 32'(tr_we[0]), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("str_addr", 32'(tr_addr[i]), (i <= 2) ? 32'd4 : 32'd5);
            chk("str_wdata", 32'(tr_wd[i]), (i <= 2) ? 32'hBEEF : 32'hDEAD);
            chk("str_we_n", 32'(tr_we[i]), 32'h0);
        end
        chk("str_done_we_n", 32'(done_we_n), 32'h1);
        chk("sram_lo", 32'(tb_sram[4]), 32'hBEEF);
        chk("sram_hi", 32'(tb_sram[5]), 32'hDEAD);

        model_op(1'b0, 2, 32'h0, exp_frz, exp_data);
        do_op(1'b0, 1'b1, 32'd1032, 32'h0, frz, rdata, tmo);
        chk("ldr_timeout", 32'(tmo), 32'h0);
        chk("ldr_freeze_cycles", 32'(frz), 32'(exp_frz));
        chk("ldr_data", rdata, 32'hDEADBEEF);

        // Non-memory instruction passes straight through.
        wb_en_in = 1'b1; alu_res_in = 32'd7; dest_in = 4'd3;
        @(negedge clk);
        chk("add_freeze", 32'(freeze), 32'h0);
        chk("add_alu_res", alu_res_out, 32'd7);
        chk("add_dest", 32'(dest_out), 32'd3);
        chk("add_wb_en", 32'(wb_en_out), 32'h1);
        chk("add_we_n", 32'(sram_we_n), 32'h1);
        chk("add_mem_data_hold", mem_data_out, 32'hDEADBEEF);
        @(posedge clk); #1;
        idle_inputs();

        // Reset during the high-half phase of a store.
        mem_w_en_in = 1'b1; alu_res_in = 32'd1044; val_rm_in = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("hi_phase_addr", 32'(sram_addr), 32'd11);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("abort_freeze", 32'(freeze), 32'h0);
        chk("abort_we_n", 32'(sram_we_n), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        rb_valid = 1'b0;
        model_op(1'b1, 5, 32'h12345678, exp_frz, exp_data);
        do_op(1'b1, 1'b0, 32'd1044, 32'h12345678, frz, rdata, tmo);
        model_op(1'b0, 2, 32'h0, exp_frz, exp_data);
        do_op(1'b0, 1'b1, 32'd1032, 32'h0, frz, rdata, tmo);
        chk("post_abort_timeout", 32'(tmo), 32'h0);
        chk("post_abort_frz", 32'(frz), 32'(exp_frz));
        chk("post_abort_data", rdata, 32'hDEADBEEF);

`ifdef MEM_STAGE_READ_BUF_EN
        model_op(1'b0, 4, 32'h0, exp_frz, exp_data);
        do_op(1'b0, 1'b1, 32'd1040, 32'h0, frz, rdata, tmo);
        model_op(1'b0, 4, 32'h0, exp_frz, exp_data);
        do_op(1'b0, 1'b1, 32'd1040, 32'h0, frz, rdata, tmo);
        chk("buf_hit_frz", 32'(frz), 32'(exp_frz));
        chk("buf_hit_data", rdata, exp_data);
        model_op(1'b1, 4, 32'hCAFEF00D, exp_frz, exp_data);
        do_op(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, frz, rdata, tmo);
        model_op(1'b0, 4, 32'h0, exp_frz, exp_data);
        do_op(1'b0, 1'b1, 32'd1040, 32'h0, frz, rdata, tmo);
        chk("buf_inval_frz", 32'(frz), 32'(exp_frz));
        chk("buf_inval_data", rdata, exp_data);
`endif

        // Randomized mix: loads, stores, both-enabled (store wins), ALU ops.
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 4));
            word = int'($urandom_range(8, 15));
            data = $urandom;
            addr = 32'(c_base + word * 4) + 32'($urandom_range(0, 3));
            if (kind == 0) begin
                wb_en_in = 1'b1; alu_res_in = data; dest_in = 4'(word);
                @(negedge clk);
                chk("rnd_alu_freeze", 32'(freeze), 32'h0);
                chk("rnd_alu_res", alu_res_out, data);
                @(posedge clk); #1;
                idle_inputs();
            end else begin
                model_op(kind != 2, word, data, exp_frz, exp_data);
                do_op(kind != 2, kind >= 2, addr, data, frz, rdata, tmo);
                chk("rnd_timeout", 32'(tmo), 32'h0);
                chk("rnd_freeze_cycles", 32'(frz), 32'(exp_frz));
                if (kind == 2) chk("rnd_load_data", rdata, exp_data);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
